// File: rtl/pc_nzp_if.sv
// pc_nzp_if: control and status bundle between execute/fetch and the PC/NZP stage
interface pc_nzp_if #(
  parameter int PC_WIDTH = 8
);
  logic                start;
  logic [PC_WIDTH-1:0] start_pc;
  logic                exec_valid;
  logic                cmp_wr_en;
  logic [2:0]          cmp_nzp;
  logic                br_en;
  logic [2:0]          br_mask;
  logic [PC_WIDTH-1:0] br_target;
  logic                halt;
  logic [PC_WIDTH-1:0] pc;
  logic [2:0]          nzp;
  logic                running;
  logic                done;
  logic                br_taken;
  modport master (
    output start, start_pc, exec_valid, cmp_wr_en, cmp_nzp, br_en, br_mask, br_target, halt,
    input  pc, nzp, running, done, br_taken
  );
  modport slave (
    input  start, start_pc, exec_valid, cmp_wr_en, cmp_nzp, br_en, br_mask, br_target, halt,
    output pc, nzp, running, done, br_taken
  );
endinterface

// File: rtl/pc_nzp_unit.sv
// pc_nzp_unit: per-thread program counter, NZP flag register and run-control FSM
module pc_nzp_unit #(
  parameter int PC_WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  pc_nzp_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [2:0]          nzp_q, nzp_d;
  logic                br_taken_q, br_taken_d;
  logic                take;
  logic                retire;
  // branch condition uses the flags registered before this edge
  assign take   = bus.br_en && ((bus.br_mask & nzp_q) != 3'b000);
  assign retire = (state_q == RUN) && bus.exec_valid;
  // next-state: launch from IDLE/DONE, retire instructions in RUN
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    nzp_d      = nzp_q;
    br_taken_d = 1'b0;
    if (state_q != RUN && bus.start) begin
      state_d = RUN;
      pc_d    = bus.start_pc;
      nzp_d   = 3'b000;
    end else if (retire) begin
      nzp_d = bus.cmp_wr_en ? bus.cmp_nzp : nzp_q;
      if (bus.halt) begin
        state_d = DONE;
      end else if (take) begin
        pc_d       = bus.br_target;
        br_taken_d = 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
      end
    end
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      nzp_q      <= 3'b000;
      br_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      nzp_q      <= nzp_d;
      br_taken_q <= br_taken_d;
    end
  end
  assign bus.pc       = pc_q;
  assign bus.nzp      = nzp_q;
  assign bus.running  = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.br_taken = br_taken_q;
endmodule

// File: tb/tb_pc_nzp_unit.sv
// tb_pc_nzp_unit: directed scoreboard bench for pc_nzp_unit
module tb_pc_nzp_unit;
  typedef struct {
    string      tag;
    logic [7:0] pc;
    logic [2:0] nzp;
    logic       running;
    logic       done;
    logic       br_taken;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  pc_nzp_if #(.PC_WIDTH(8)) bus ();
  pc_nzp_unit #(.PC_WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input string f, input logic [7:0] got, input logic [7:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s.%s got=%0h want=%0h", tag, f, got, want);
    end
  endtask
  task automatic drive(input logic s, input logic [7:0] spc, input logic ev, input logic cw,
                       input logic [2:0] cn, input logic be, input logic [2:0] bm,
                       input logic [7:0] bt, input logic h);
    bus.start      = s;
    bus.start_pc   = spc;
    bus.exec_valid = ev;
    bus.cmp_wr_en  = cw;
    bus.cmp_nzp    = cn;
    bus.br_en      = be;
    bus.br_mask    = bm;
    bus.br_target  = bt;
    bus.halt       = h;
  endtask
  task automatic tick(input string tag, input logic [7:0] p, input logic [2:0] n,
                      input logic r, input logic d, input logic b);
    exp_t e;
    sb.push_back('{tag, p, n, r, d, b});
    @(posedge clk);
    #1;
    drive(0, 8'h00, 0, 0, 3'b000, 0, 3'b000, 8'h00, 0);
    e = sb.pop_front();
    chk(e.tag, "pc", bus.pc, e.pc);
    chk(e.tag, "nzp", {5'd0, bus.nzp}, {5'd0, e.nzp});
    chk(e.tag, "running", {7'd0, bus.running}, {7'd0, e.running});
    chk(e.tag, "done", {7'd0, bus.done}, {7'd0, e.done});
    chk(e.tag, "br_taken", {7'd0, bus.br_taken}, {7'd0, e.br_taken});
  endtask
  initial begin
    rst_n = 1'b0;
    drive(0, 8'h00, 0, 0, 3'b000, 0, 3'b000, 8'h00, 0);
    tick("reset", 8'h00, 3'b000, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 8'h00, 1, 0, 3'b000, 0, 3'b000, 8'h00, 0);
    tick("idle_ev", 8'h00, 3'b000, 0, 0, 0);
    drive(1, 8'h10, 0, 0, 3'b000, 0, 3'b000, 8'h00, 0);
    tick("launch10", 8'h10, 3'b000, 1, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      drive(0, 8'h00, 1, 0, 3'b000, 0, 3'b000, 8'h00, 0);
      tick("seq1x", 8'h10 + 8'(i), 3'b000, 1, 0, 0);
    end
    rst_n = 1'b0;
    drive(0, 8'h00, 1, 1, 3'b100, 0, 3'b000, 8'h00, 0);
    tick("rst_mid", 8'h00, 3'b000, 0, 0, 0);
    rst_n = 1'b1;
    drive(0, 8'h00, 1, 1, 3'b100, 0, 3'b000, 8'h00, 0);
    tick("post_rst_ev", 8'h00, 3'b000, 0, 0, 0);
    drive(1, 8'hFE, 1, 0, 3'b000, 0, 3'b000, 8'h00, 0);
    tick("launchFE", 8'hFE, 3'b000, 1, 0, 0);
    drive(0, 8'h00, 1, 0, 3'b000, 0, 3'b000, 8'h00, 0);
    tick("wrapFF", 8'hFF, 3'b000, 1, 0, 0);
    drive(0, 8'h00, 1, 0, 3'b000, 0, 3'b000, 8'h00, 0);
    tick("wrap00", 8'h00, 3'b000, 1, 0, 0);
    drive(0, 8'h00, 1, 0, 3'b000, 0, 3'b000, 8'h00, 0);
    tick("wrap01", 8'h01, 3'b000, 1, 0, 0);
    drive(0, 8'h00, 1, 1, 3'b100, 0, 3'b000, 8'h00, 0);
    tick("cmp100", 8'h02, 3'b100, 1, 0, 0);
    drive(0, 8'h00, 1, 0, 3'b000, 1, 3'b100, 8'h40, 0);
    tick("br_taken", 8'h40, 3'b100, 1, 0, 1);
    drive(0, 8'h00, 1, 0, 3'b000, 0, 3'b000, 8'h00, 0);
    tick("bt_clear", 8'h41, 3'b100, 1, 0, 0);
    drive(0, 8'h00, 1, 0, 3'b000, 1, 3'b011, 8'h40, 0);
    tick("br_not", 8'h42, 3'b100, 1, 0, 0);
    drive(0, 8'h00, 1, 1, 3'b010, 0, 3'b000, 8'h00, 0);
    tick("cmp010", 8'h43, 3'b010, 1, 0, 0);
    drive(0, 8'h00, 1, 1, 3'b001, 1, 3'b001, 8'h20, 0);
    tick("cmp_br_same", 8'h44, 3'b001, 1, 0, 0);
    drive(0, 8'h00, 0, 0, 3'b000, 0, 3'b000, 8'h00, 0);
    tick("no_ev", 8'h44, 3'b001, 1, 0, 0);
    drive(1, 8'h77, 0, 0, 3'b000, 0, 3'b000, 8'h00, 0);
    tick("start_in_run", 8'h44, 3'b001, 1, 0, 0);
    drive(0, 8'h00, 1, 1, 3'b100, 1, 3'b001, 8'h55, 1);
    tick("halt", 8'h44, 3'b100, 0, 1, 0);
    drive(0, 8'h00, 1, 0, 3'b000, 0, 3'b000, 8'h00, 0);
    tick("done_ev", 8'h44, 3'b100, 0, 1, 0);
    drive(1, 8'h05, 0, 0, 3'b000, 0, 3'b000, 8'h00, 0);
    tick("relaunch", 8'h05, 3'b000, 1, 0, 0);
    drive(0, 8'h00, 1, 0, 3'b000, 1, 3'b111, 8'h33, 0);
    tick("br_nocmp", 8'h06, 3'b000, 1, 0, 0);
    drive(0, 8'h00, 1, 1, 3'b111, 0, 3'b000, 8'h00, 0);
    tick("cmp111", 8'h07, 3'b111, 1, 0, 0);
    drive(0, 8'h00, 1, 0, 3'b000, 1, 3'b000, 8'h33, 0);
    tick("mask000", 8'h08, 3'b111, 1, 0, 0);
    drive(0, 8'h00, 1, 0, 3'b000, 1, 3'b010, 8'hFF, 0);
    tick("br_ff", 8'hFF, 3'b111, 1, 0, 1);
    drive(0, 8'h00, 1, 0, 3'b000, 1, 3'b001, 8'h10, 0);
    tick("br_b2b", 8'h10, 3'b111, 1, 0, 1);
    drive(0, 8'h00, 1, 0, 3'b000, 0, 3'b000, 8'h00, 0);
    tick("after_b2b", 8'h11, 3'b111, 1, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
